// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, fetches one word over valid/ready,
// presents it to the CPU until commit, and latches a sticky fault on errors.
module ifu_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [31:0]      imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   input  logic             imem_rsp_err,
   output logic [31:0]      pc,
   output logic [31:0]      inst,
   output logic             inst_valid,
   input  logic             inst_ready,
   input  logic [31:0]      npc,
   output logic             fetch_fault,
   output logic [31:0]      fault_pc,
   output logic [CNT_W-1:0] retired_cnt
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      inst_q, inst_d;
   logic             inst_valid_q, inst_valid_d;
   logic             fault_q, fault_d;
   logic [31:0]      fault_pc_q, fault_pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      fault_d      = fault_q;
      fault_pc_d   = fault_pc_q;
      cnt_d        = cnt_q;
      case (state_q)
         S_REQ: begin
            if (imem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               if (imem_rsp_err) begin
                  fault_d    = 1'b1;
                  fault_pc_d = pc_q;
                  state_d    = S_FAULT;
               end else begin
                  inst_d       = imem_rsp_data;
                  inst_valid_d = 1'b1;
                  state_d      = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            // The committed instruction retires even if its successor is misaligned.
            if (inst_ready) begin
               cnt_d        = cnt_q + CNT_W'(1);
               inst_valid_d = 1'b0;
               if (npc[1:0] == 2'b00) begin
                  pc_d    = npc;
                  state_d = S_REQ;
               end else begin
                  fault_d    = 1'b1;
                  fault_pc_d = npc;
                  state_d    = S_FAULT;
               end
            end
         end
         default: begin
            state_d = S_FAULT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         inst_q       <= NOP;
         inst_valid_q <= 1'b0;
         fault_q      <= 1'b0;
         fault_pc_q   <= 32'h0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         fault_q      <= fault_d;
         fault_pc_q   <= fault_pc_d;
         cnt_q        <= cnt_d;
      end
   end

   assign imem_req_valid = (state_q == S_REQ);
   assign imem_req_addr  = pc_q;
   assign pc             = pc_q;
   assign inst           = inst_q;
   assign inst_valid     = inst_valid_q;
   assign fetch_fault    = fault_q;
   assign fault_pc       = fault_pc_q;
   assign retired_cnt    = cnt_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: vector table plus stall, fault and counter-wrap sequences.
module tb_ifu_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst, rr, rv, re, ir;
   logic [31:0] rd, npc;

   logic        rqv, iv, flt;
   logic [31:0] addr, pc, inst, fpc, cnt;
   logic        rqv2, iv2, flt2;
   logic [31:0] addr2, pc2, inst2, fpc2;
   logic [3:0]  cnt2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ifu_fetch_ctrl #(.RESET_PC(32'h8000_0000), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(rqv), .imem_req_ready(rr), .imem_req_addr(addr),
      .imem_rsp_valid(rv), .imem_rsp_data(rd), .imem_rsp_err(re),
      .pc(pc), .inst(inst), .inst_valid(iv), .inst_ready(ir), .npc(npc),
      .fetch_fault(flt), .fault_pc(fpc), .retired_cnt(cnt)
   );

   // Narrow-counter instance sharing all stimulus, used for the wrap check.
   ifu_fetch_ctrl #(.RESET_PC(32'h8000_0000), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .imem_req_valid(rqv2), .imem_req_ready(rr), .imem_req_addr(addr2),
      .imem_rsp_valid(rv), .imem_rsp_data(rd), .imem_rsp_err(re),
      .pc(pc2), .inst(inst2), .inst_valid(iv2), .inst_ready(ir), .npc(npc),
      .fetch_fault(flt2), .fault_pc(fpc2), .retired_cnt(cnt2)
   );

   typedef struct {
      logic        rst, rr, rv, re, ir;
      logic [31:0] rd, npc;
      logic        e_rqv, e_iv, e_flt;
      logic [31:0] e_pc, e_inst, e_fpc, e_cnt;
   } vec_t;

   vec_t vt[18];

   function automatic vec_t mk(input logic r, input logic q, input logic v, input logic e,
                               input logic i, input logic [31:0] d, input logic [31:0] n,
                               input logic x_rqv, input logic x_iv, input logic x_flt,
                               input logic [31:0] x_pc, input logic [31:0] x_inst,
                               input logic [31:0] x_fpc, input logic [31:0] x_cnt);
      vec_t t;
      t.rst = r; t.rr = q; t.rv = v; t.re = e; t.ir = i; t.rd = d; t.npc = n;
      t.e_rqv = x_rqv; t.e_iv = x_iv; t.e_flt = x_flt;
      t.e_pc = x_pc; t.e_inst = x_inst; t.e_fpc = x_fpc; t.e_cnt = x_cnt;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      rst = 1'b1; rr = 1'b0; rv = 1'b0; re = 1'b0; ir = 1'b0; rd = 32'h0; npc = 32'h0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;

      vt[0]  = mk(0,0,0,0,0, 32'h0,        32'h0,        1,0,0, 32'h8000_0000, 32'h0000_0013, 32'h0,         0);
      vt[1]  = mk(1,1,0,0,0, 32'h0,        32'h0,        0,0,0, 32'h8000_0000, 32'h0000_0013, 32'h0,         0);
      vt[2]  = mk(1,0,1,0,0, 32'h00500093, 32'h0,        0,1,0, 32'h8000_0000, 32'h00500093, 32'h0,         0);
      vt[3]  = mk(1,0,0,0,1, 32'h0,        32'h8000_0004,1,0,0, 32'h8000_0004, 32'h00500093, 32'h0,         1);
      vt[4]  = mk(1,1,0,0,0, 32'h0,        32'h0,        0,0,0, 32'h8000_0004, 32'h00500093, 32'h0,         1);
      vt[5]  = mk(1,0,1,0,0, 32'h00100113, 32'h0,        0,1,0, 32'h8000_0004, 32'h00100113, 32'h0,         1);
      vt[6]  = mk(1,0,0,0,1, 32'h0,        32'h8000_0008,1,0,0, 32'h8000_0008, 32'h00100113, 32'h0,         2);
      vt[7]  = mk(1,1,0,0,0, 32'h0,        32'h0,        0,0,0, 32'h8000_0008, 32'h00100113, 32'h0,         2);
      vt[8]  = mk(1,0,1,1,0, 32'hdeadbeef, 32'h0,        0,0,1, 32'h8000_0008, 32'h00100113, 32'h8000_0008, 2);
      vt[9]  = mk(1,1,1,0,1, 32'h12345678, 32'h8000_0010,0,0,1, 32'h8000_0008, 32'h00100113, 32'h8000_0008, 2);
      vt[10] = mk(0,0,1,0,0, 32'h12345678, 32'h0,        1,0,0, 32'h8000_0000, 32'h0000_0013, 32'h0,         0);
      vt[11] = mk(1,0,1,0,0, 32'hcafef00d, 32'h0,        1,0,0, 32'h8000_0000, 32'h0000_0013, 32'h0,         0);
      vt[12] = mk(1,1,0,0,1, 32'h0,        32'h8000_0040,0,0,0, 32'h8000_0000, 32'h0000_0013, 32'h0,         0);
      vt[13] = mk(0,0,1,0,0, 32'hcafef00d, 32'h0,        1,0,0, 32'h8000_0000, 32'h0000_0013, 32'h0,         0);
      vt[14] = mk(1,1,0,1,0, 32'h0,        32'h0,        0,0,0, 32'h8000_0000, 32'h0000_0013, 32'h0,         0);
      vt[15] = mk(1,0,0,1,1, 32'h0,        32'h8000_0080,0,0,0, 32'h8000_0000, 32'h0000_0013, 32'h0,         0);
      vt[16] = mk(1,0,1,0,0, 32'h00000533, 32'h0,        0,1,0, 32'h8000_0000, 32'h00000533, 32'h0,         0);
      vt[17] = mk(1,0,0,0,1, 32'h0,        32'h8000_0102,0,0,1, 32'h8000_0000, 32'h00000533, 32'h8000_0102, 1);

      for (int k = 0; k < 18; k++) begin
         rst = vt[k].rst; rr = vt[k].rr; rv = vt[k].rv; re = vt[k].re;
         ir = vt[k].ir; rd = vt[k].rd; npc = vt[k].npc;
         tick();
         $display("vec %0d: rqv=%0d addr=%h iv=%0d inst=%h flt=%0d fpc=%h cnt=%0d",
                  k, rqv, addr, iv, inst, flt, fpc, cnt);
         chk($sformatf("v%0d.req_valid", k),   {31'b0, rqv}, {31'b0, vt[k].e_rqv});
         chk($sformatf("v%0d.req_addr", k),    addr,         vt[k].e_pc);
         chk($sformatf("v%0d.pc", k),          pc,           vt[k].e_pc);
         chk($sformatf("v%0d.inst_valid", k),  {31'b0, iv},  {31'b0, vt[k].e_iv});
         chk($sformatf("v%0d.inst", k),        inst,         vt[k].e_inst);
         chk($sformatf("v%0d.fetch_fault", k), {31'b0, flt}, {31'b0, vt[k].e_flt});
         chk($sformatf("v%0d.fault_pc", k),    fpc,          vt[k].e_fpc);
         chk($sformatf("v%0d.retired", k),     cnt,          vt[k].e_cnt);
         chk($sformatf("v%0d.retired4", k),    {28'b0, cnt2}, {28'b0, vt[k].e_cnt[3:0]});
      end

      // Misaligned-npc fault must stay silent on the request port.
      idle_inputs();
      rr = 1'b1; rv = 1'b1; ir = 1'b1; npc = 32'h8000_0200;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk($sformatf("fault_hold%0d.req_valid", k), {31'b0, rqv}, 32'h0);
         chk($sformatf("fault_hold%0d.fault", k),     {31'b0, flt}, 32'h1);
      end
      $display("fault hold: fpc=%h cnt=%0d", fpc, cnt);
      chk("fault_hold.retired", cnt, 32'd1);

      // Back-pressure on both the request and the CPU side.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("req_stall%0d.valid", k), {31'b0, rqv}, 32'h1);
         chk($sformatf("req_stall%0d.addr", k),  addr,         32'h8000_0000);
      end
      rr = 1'b1;
      tick();
      rr = 1'b0;
      chk("accept.valid", {31'b0, rqv}, 32'h0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("rsp_wait%0d.req_valid", k),  {31'b0, rqv}, 32'h0);
         chk($sformatf("rsp_wait%0d.inst_valid", k), {31'b0, iv},  32'h0);
      end
      rv = 1'b1; rd = 32'h00A00113;
      tick();
      rv = 1'b0; rd = 32'h0;
      chk("rsp.inst_valid", {31'b0, iv}, 32'h1);
      chk("rsp.inst", inst, 32'h00A00113);
      for (int k = 0; k < 10; k++) begin
         npc = 32'h8000_0200 + 32'(k * 4);
         tick();
         chk($sformatf("hold%0d.pc", k),    pc,   32'h8000_0000);
         chk($sformatf("hold%0d.inst", k),  inst, 32'h00A00113);
         chk($sformatf("hold%0d.valid", k), {31'b0, iv}, 32'h1);
      end
      ir = 1'b1; npc = 32'h8000_0100;
      tick();
      ir = 1'b0; npc = 32'h8000_0300;
      $display("commit after hold: rqv=%0d addr=%h cnt=%0d", rqv, addr, cnt);
      chk("commit.req_valid", {31'b0, rqv}, 32'h1);
      chk("commit.req_addr",  addr,         32'h8000_0100);
      chk("commit.retired",   cnt,          32'd1);

      // Seventeen back-to-back commits: the 4-bit counter wraps to 1.
      do_reset();
      for (int k = 0; k < 17; k++) begin
         rr = 1'b1;
         tick();
         rr = 1'b0; rv = 1'b1; rd = 32'h0000_0013;
         tick();
         rv = 1'b0; ir = 1'b1; npc = 32'h8000_0000 + 32'((k + 1) * 4);
         tick();
         ir = 1'b0;
         $display("wrap commit %0d: addr=%h cnt=%0d cnt4=%0d", k, addr, cnt, cnt2);
         chk($sformatf("wrap%0d.addr", k),     addr, 32'h8000_0000 + 32'((k + 1) * 4));
         chk($sformatf("wrap%0d.retired", k),  cnt,  32'(k + 1));
         chk($sformatf("wrap%0d.retired4", k), {28'b0, cnt2}, 32'((k + 1) % 16));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
